spi_target_regs: RTL and testbench

- SPI responder (target) with an internal 8-bit register file, clocked entirely in the system `clk` domain.
- SPI pins are oversampled; no logic runs on `sclk` as a clock.
- Answers a master of the existing SPI subsystem with a command-byte + burst-data protocol.
- Exposes the register contents and a write-notify strobe to local logic.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_pin_sync.sv | 53 +++++
 rtl/spi_target_regs.sv | 183 ++++++++++++++++++
 tb/tb_spi_target_regs.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : spi_pkg
// Brief  : Shared state encoding and field constants for the SPI register target.
// Rev    : 1.0
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        CMD       = 2'd2,
        DATA      = 2'd3
    } state_t;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 7;
    localparam int CPOL_BIT   = 1;
    localparam int CPHA_BIT   = 0;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : spi_pin_sync
// Brief  : Two-flop synchronizers for the SPI pins plus sclk/cs_n edge detect.
// Rev    : 1.0
// ============================================================================
module spi_pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    input  logic i_cpol,
    output logic sclk_lead,
    output logic sclk_trail,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s,
    output logic cs_n_s
);

    // Index 1 is the synchronized value, index 2 the delayed copy for edges.
    logic [2:0] r_sclk;
    logic [2:0] r_cs;
    logic [1:0] r_mosi;
    logic       w_sclk_rise;
    logic       w_sclk_fall;

    // cs_n resets to "selected" so a frame in flight is never mistaken for a new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk <= 3'b000;
            r_cs   <= 3'b000;
            r_mosi <= 2'b00;
        end else begin
            r_sclk <= {r_sclk[1:0], sclk};
            r_cs   <= {r_cs[1:0], cs_n};
            r_mosi <= {r_mosi[0], mosi};
        end
    end

    assign w_sclk_rise = r_sclk[1] & ~r_sclk[2];
    assign w_sclk_fall = ~r_sclk[1] & r_sclk[2];
    assign sclk_lead   = i_cpol ? w_sclk_fall : w_sclk_rise;
    assign sclk_trail  = i_cpol ? w_sclk_rise : w_sclk_fall;
    assign cs_fall     = ~r_cs[1] & r_cs[2];
    assign cs_rise     = r_cs[1] & ~r_cs[2];
    assign mosi_s      = r_mosi[1];
    assign cs_n_s      = r_cs[1];

endmodule
`default_nettype wire

// File: rtl/spi_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : spi_target_regs
// Brief  : SPI target with an 8-bit register file, oversampled in clk domain.
//          Define SPI_TARGET_XFER_CNT_EN for a write counter at addr NUM_REGS.
// Rev    : 1.0
// ============================================================================
module spi_target_regs
    import spi_pkg::*;
#(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [1:0]            MODE,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data
);

    localparam logic [ADDR_W:0] c_NUM_REGS = NUM_REGS[ADDR_W:0];

    logic              w_lead, w_trail, w_cs_fall, w_cs_rise, w_mosi, w_cs_n;
    logic              w_sample, w_shift, w_byte_done, w_next_rw, w_in_range;
    logic [7:0]        w_byte, w_rd_next, w_rd_cur, w_tx_next, w_tx_cur;
    logic [ADDR_W-1:0] w_next_addr;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [2:0]        r_bitcnt;
    logic [6:0]        r_rx;
    logic [7:0]        r_tx;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load_pend;
    logic              r_miso;
    logic [7:0]        r_regs [NUM_REGS];
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
`ifdef SPI_TARGET_XFER_CNT_EN
    logic [7:0]        r_xfer_cnt;
`endif

    spi_pin_sync u_pin_sync (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .i_cpol     (r_mode[CPOL_BIT]),
        .sclk_lead  (w_lead),
        .sclk_trail (w_trail),
        .cs_fall    (w_cs_fall),
        .cs_rise    (w_cs_rise),
        .mosi_s     (w_mosi),
        .cs_n_s     (w_cs_n)
    );

    assign w_sample    = r_mode[CPHA_BIT] ? w_trail : w_lead;
    assign w_shift     = r_mode[CPHA_BIT] ? w_lead : w_trail;
    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_sample && (r_bitcnt == 3'd7);
    assign w_next_rw   = (r_state == CMD) ? w_byte[CMD_RW_BIT] : r_rw;
    assign w_next_addr = (r_state == CMD) ? w_byte[ADDR_W-1:0] : r_addr + 7'd1;
    assign w_in_range  = {1'b0, r_addr} < c_NUM_REGS;

    // w_rd_next feeds the CPHA=1 load at the sample edge, w_rd_cur the deferred CPHA=0 load.
    always_comb begin
        w_rd_next = 8'h00;
        w_rd_cur  = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_next_addr == ADDR_W'(i)) w_rd_next = r_regs[i];
            if (r_addr == ADDR_W'(i))      w_rd_cur  = r_regs[i];
        end
`ifdef SPI_TARGET_XFER_CNT_EN
        if ({1'b0, w_next_addr} == c_NUM_REGS) w_rd_next = r_xfer_cnt;
        if ({1'b0, r_addr} == c_NUM_REGS)      w_rd_cur  = r_xfer_cnt;
`endif
    end

    assign w_tx_next = w_next_rw ? w_rd_next : 8'h00;
    assign w_tx_cur  = r_rw ? w_rd_cur : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT_IDLE;
            r_mode      <= 2'b00;
            r_bitcnt    <= 3'd0;
            r_rx        <= 7'd0;
            r_tx        <= 8'h00;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_load_pend <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
`ifdef SPI_TARGET_XFER_CNT_EN
            r_xfer_cnt  <= 8'h00;
`endif
        end else begin
            r_wr_valid <= 1'b0;
            case (r_state)
                WAIT_IDLE: begin
                    if (w_cs_n) r_state <= IDLE;
                end
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state     <= CMD;
                        r_mode      <= MODE;
                        r_bitcnt    <= 3'd0;
                        r_rx        <= 7'd0;
                        r_tx        <= 8'h00;
                        r_load_pend <= 1'b0;
                        r_miso      <= 1'b0;
                    end
                end
                default: begin
                    // Deselect outranks a byte completing in the same cycle.
                    if (w_cs_rise) begin
                        r_state     <= IDLE;
                        r_bitcnt    <= 3'd0;
                        r_tx        <= 8'h00;
                        r_load_pend <= 1'b0;
                        r_miso      <= 1'b0;
                    end else if (w_sample) begin
                        r_rx     <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_byte_done) begin
                            r_state <= DATA;
                            r_rw    <= w_next_rw;
                            r_addr  <= w_next_addr;
                            if (r_mode[CPHA_BIT]) r_tx <= w_tx_next;
                            else                  r_load_pend <= 1'b1;
                            if (r_state == DATA && !r_rw && w_in_range) begin
                                for (int i = 0; i < NUM_REGS; i++)
                                    if (r_addr == ADDR_W'(i)) r_regs[i] <= w_byte;
                                r_wr_valid <= 1'b1;
                                r_wr_addr  <= r_addr;
                                r_wr_data  <= w_byte;
`ifdef SPI_TARGET_XFER_CNT_EN
                                r_xfer_cnt <= r_xfer_cnt + 8'd1;
`endif
                            end
                        end
                    end else if (w_shift) begin
                        if (r_mode[CPHA_BIT]) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end else if (r_load_pend) begin
                            r_tx        <= w_tx_cur;
                            r_load_pend <= 1'b0;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = r_regs[g];
    end

    assign miso_oe  = (r_state != WAIT_IDLE) && !w_cs_n;
    assign miso     = miso_oe && (r_mode[CPHA_BIT] ? r_miso : r_tx[7]);
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_spi_target_regs
// Brief  : Directed SPI master frames with scoreboarded write and read checks.
// Rev    : 1.0
// ============================================================================
module tb_spi_target_regs;

    localparam int NREGS = 8;
    localparam int H     = 80;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               sclk  = 1'b0;
    logic               cs_n  = 1'b1;
    logic               mosi  = 1'b0;
    logic [1:0]         MODE  = 2'b00;
    logic               miso, miso_oe, wr_valid;
    logic [8*NREGS-1:0] regs_flat;
    logic [6:0]         wr_addr;
    logic [7:0]         wr_data;

    always #5 clk = ~clk;

    spi_target_regs #(.NUM_REGS(NREGS), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .MODE      (MODE),
        .regs_flat (regs_flat),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    typedef struct packed {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    wr_t        wr_exp_e;
    logic [7:0] exp_rd[$];
    logic [7:0] rd_exp_b;
    logic [7:0] exp_regs [NREGS];
    logic [7:0] n_commits;
    int         n_checks = 0;
    int         n_err    = 0;

    logic [1:0] m_mode   = 2'b00;
    logic       m_chk    = 1'b0;
    logic       m_sclk_q = 1'b0;
    logic [7:0] mon_sh   = 8'h00;
    int         mon_n    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            chk($sformatf("%s_reg%0d", tag, i), {24'h0, regs_flat[8*i +: 8]}, {24'h0, exp_regs[i]});
    endtask

    task automatic exp_write(input logic [6:0] a, input logic [7:0] d);
        exp_wr.push_back('{a: a, d: d});
        exp_regs[a] = d;
        n_commits   = n_commits + 8'd1;
    endtask

    // One master frame; data is MSB-first from bit 31. chg_bit/rst_bit < 0 disable those events.
    task automatic frame(input logic [1:0] md, input logic [31:0] data, input int nbits,
                         input int chg_bit, input logic [1:0] chg_mode, input int rst_bit,
                         input logic chk_rd);
        logic cpol, cpha;
        cpol = md[1];
        cpha = md[0];
        @(negedge clk);
        sclk   = cpol;
        mosi   = 1'b0;
        MODE   = md;
        m_mode = md;
        m_chk  = chk_rd;
        #(H);
        cs_n = 1'b0;
        #(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) MODE = chg_mode;
            if (i == rst_bit) reset = 1'b1;
            if (!cpha) begin
                mosi = data[31-i];
                #(H);
                sclk = ~cpol;
                #(H);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = data[31-i];
                #(H);
                sclk = cpol;
                #(H);
            end
            reset = 1'b0;
        end
        #(H);
        cs_n = 1'b1;
        #(2*H);
        m_chk = 1'b0;
    endtask

    // Write-side monitor: every wr_valid cycle consumes one expected commit.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got addr %0d data %02h, none expected", wr_addr, wr_data);
            end else begin
                wr_exp_e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== {wr_exp_e.a, wr_exp_e.d}) begin
                    n_err++;
                    $display("FAIL wr_commit: got addr %0d data %02h expected addr %0d data %02h",
                             wr_addr, wr_data, wr_exp_e.a, wr_exp_e.d);
                end
            end
        end
    end

    // Read-side monitor: rebuilds miso bytes on the master's sample edges.
    initial begin
        forever begin
            @(sclk or cs_n);
            if (cs_n) begin
                mon_n = 0;
            end else if ((sclk !== m_sclk_q) && m_chk && ((sclk != m_mode[1]) != m_mode[0])) begin
                mon_sh = {mon_sh[6:0], miso};
                mon_n++;
                if (mon_n == 8) begin
                    mon_n = 0;
                    n_checks++;
                    if (exp_rd.size() == 0) begin
                        n_err++;
                        $display("FAIL rd_unexpected: got %02h, no byte expected", mon_sh);
                    end else begin
                        rd_exp_b = exp_rd.pop_front();
                        if (mon_sh !== rd_exp_b) begin
                            n_err++;
                            $display("FAIL rd_byte: got %02h expected %02h", mon_sh, rd_exp_b);
                        end
                    end
                end
            end
            m_sclk_q = sclk;
        end
    end

    initial begin
        n_commits = 8'h00;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("rst_wr_addr", {25'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        chk("rst_miso", {31'h0, miso}, 32'h0);
        check_regs("rst");

        // Mode 0 single write.
        exp_write(7'd2, 8'hA5);
        frame(2'd0, 32'h02A5_0000, 16, -1, 2'd0, -1, 1'b0);
        check_regs("m0_write");

        // Mode 3 burst write then burst read; CMD byte reads back as 0x00.
        exp_write(7'd0, 8'h11);
        exp_write(7'd1, 8'h22);
        exp_write(7'd2, 8'h33);
        frame(2'd3, 32'h0011_2233, 32, -1, 2'd0, -1, 1'b0);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        frame(2'd3, 32'h8000_0000, 32, -1, 2'd0, -1, 1'b1);
        check_regs("m3_burst");

        // Mode 1 aborted partial byte, then a normal write and read.
        frame(2'd1, 32'h04F0_0000, 13, -1, 2'd0, -1, 1'b0);
        check_regs("m1_partial");
        exp_write(7'd4, 8'h4D);
        frame(2'd1, 32'h044D_0000, 16, -1, 2'd0, -1, 1'b0);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h4D);
        frame(2'd1, 32'h8400_0000, 16, -1, 2'd0, -1, 1'b1);
        check_regs("m1_after");

        // Write crossing the top of the register file, then out-of-range read.
        exp_write(7'd7, 8'hAA);
        frame(2'd0, 32'h07AA_BB00, 24, -1, 2'd0, -1, 1'b0);
        check_regs("m0_edge");
        exp_rd.push_back(8'h00);
`ifdef SPI_TARGET_XFER_CNT_EN
        exp_rd.push_back(n_commits);
`else
        exp_rd.push_back(8'h00);
`endif
        exp_rd.push_back(8'h00);
        frame(2'd0, 32'h8800_0000, 24, -1, 2'd0, -1, 1'b1);

        // Reset in the middle of a write frame.
        frame(2'd0, 32'h035C_0000, 16, -1, 2'd0, 11, 1'b0);
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
        n_commits = 8'h00;
        check_regs("mid_reset");
        exp_write(7'd1, 8'h3C);
        frame(2'd0, 32'h013C_0000, 16, -1, 2'd0, -1, 1'b0);
        check_regs("post_reset");

        // MODE change while selected only takes effect on the next frame.
        exp_write(7'd5, 8'h66);
        frame(2'd0, 32'h0566_0000, 16, 4, 2'd2, -1, 1'b0);
        exp_write(7'd6, 8'h99);
        frame(2'd2, 32'h0699_0000, 16, -1, 2'd0, -1, 1'b0);
        exp_rd.push_back(8'h00);
        exp_rd.push_back(8'h66);
        exp_rd.push_back(8'h99);
        frame(2'd2, 32'h8500_0000, 24, -1, 2'd0, -1, 1'b1);
        check_regs("mode_latch");

        repeat (10) @(negedge clk);
        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        chk("rd_queue_drained", exp_rd.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
